// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/exception carry, deferred flush
// across holds, and saturating hold/bubble performance counters.
module pipe_stage_reg #(
  parameter int unsigned               DATA_W   = 32,
  parameter int unsigned               PC_W     = 32,
  parameter logic [DATA_W-1:0]         NOP_DATA = '0,
  parameter logic [PC_W-1:0]           RESET_PC = '0,
  parameter int unsigned               CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              busy_i,
  input  logic              busy_sens_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [4:0]        excode_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [4:0]        excode_o,
  output logic              hold_o,
  output logic              flush_pend_o,
  output logic [CNT_W-1:0]  hold_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HOLD    = 2'd1,
    HOLD_FP = 2'd2
  } state_t;

  state_t state, state_next;
  logic   hold;
  logic   bubble;

  assign hold         = stall_i | (busy_i & busy_sens_i);
  assign hold_o       = hold;
  assign flush_pend_o = (state == HOLD_FP);

  // A flush seen during a hold is parked in HOLD_FP and becomes exactly one
  // bubble on the first free edge; a coincident flush_i is absorbed by it.
  assign bubble = ~hold & (flush_i | (state == HOLD_FP));

  always_comb begin
    state_next = RUN;
    if (hold) begin
      if (flush_i || state == HOLD_FP) state_next = HOLD_FP;
      else                             state_next = HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_o      <= 1'b0;
      data_o       <= NOP_DATA;
      pc_o         <= RESET_PC;
      excode_o     <= '0;
      hold_cnt_o   <= '0;
      bubble_cnt_o <= '0;
    end else if (hold) begin
      if (hold_cnt_o != '1) hold_cnt_o <= hold_cnt_o + CNT_W'(1);
    end else if (bubble) begin
      valid_o  <= 1'b0;
      data_o   <= NOP_DATA;
      pc_o     <= pc_i;
      excode_o <= '0;
      if (bubble_cnt_o != '1) bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
    end else begin
      valid_o  <= valid_i;
      data_o   <= data_i;
      pc_o     <= pc_i;
      excode_o <= excode_i;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: explicit vector table, hand-written corner
// sequences and randomized traffic against a behavioural model.
module tb_pipe_stage_reg;

  localparam logic [31:0] NOP2 = 32'hDEAD_BEEF;
  localparam logic [31:0] RPC2 = 32'hBFC0_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, busy, bsens, flush, valid;
  logic [31:0] data, pc;
  logic [4:0]  ex;

  logic        v1, hold1, pend1;
  logic [31:0] d1, p1;
  logic [4:0]  e1;
  logic [15:0] hc1, bc1;

  logic        v2, hold2, pend2;
  logic [31:0] d2, p2;
  logic [4:0]  e2;
  logic [1:0]  hc2, bc2;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .stall_i(stall), .busy_i(busy), .busy_sens_i(bsens),
    .flush_i(flush), .valid_i(valid), .data_i(data), .pc_i(pc), .excode_i(ex),
    .valid_o(v1), .data_o(d1), .pc_o(p1), .excode_o(e1), .hold_o(hold1),
    .flush_pend_o(pend1), .hold_cnt_o(hc1), .bubble_cnt_o(bc1)
  );

  pipe_stage_reg #(.CNT_W(2), .NOP_DATA(NOP2), .RESET_PC(RPC2)) dut2 (
    .clk(clk), .reset(reset), .stall_i(stall), .busy_i(busy), .busy_sens_i(bsens),
    .flush_i(flush), .valid_i(valid), .data_i(data), .pc_i(pc), .excode_i(ex),
    .valid_o(v2), .data_o(d2), .pc_o(p2), .excode_o(e2), .hold_o(hold2),
    .flush_pend_o(pend2), .hold_cnt_o(hc2), .bubble_cnt_o(bc2)
  );

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [31:0] p;
    logic [4:0]  e;
    logic        pend;
    int unsigned hc;
    int unsigned bc;
  } mstate_t;

  mstate_t m1, m2;

  function automatic mstate_t reset_state(logic [31:0] nop, logic [31:0] rpc);
    mstate_t s;
    s.v = 1'b0; s.d = nop; s.p = rpc; s.e = 5'd0; s.pend = 1'b0; s.hc = 0; s.bc = 0;
    return s;
  endfunction

  // One clock edge of the register, straight from the priority rules.
  function automatic mstate_t mstep(mstate_t s, logic [31:0] nop, logic [31:0] rpc,
                                    int unsigned cmax);
    mstate_t n = s;
    if (reset) n = reset_state(nop, rpc);
    else if (stall || (busy && bsens)) begin
      if (s.hc < cmax) n.hc = s.hc + 1;
      n.pend = s.pend || flush;
    end else if (flush || s.pend) begin
      n.v = 1'b0; n.d = nop; n.e = 5'd0; n.p = pc; n.pend = 1'b0;
      if (s.bc < cmax) n.bc = s.bc + 1;
    end else begin
      n.v = valid; n.d = data; n.p = pc; n.e = ex;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_models();
    chk("m1.valid", 64'(v1), 64'(m1.v));
    chk("m1.data", 64'(d1), 64'(m1.d));
    chk("m1.pc", 64'(p1), 64'(m1.p));
    chk("m1.excode", 64'(e1), 64'(m1.e));
    chk("m1.pend", 64'(pend1), 64'(m1.pend));
    chk("m1.hold_cnt", 64'(hc1), 64'(m1.hc));
    chk("m1.bubble_cnt", 64'(bc1), 64'(m1.bc));
    chk("m2.valid", 64'(v2), 64'(m2.v));
    chk("m2.data", 64'(d2), 64'(m2.d));
    chk("m2.pc", 64'(p2), 64'(m2.p));
    chk("m2.excode", 64'(e2), 64'(m2.e));
    chk("m2.pend", 64'(pend2), 64'(m2.pend));
    chk("m2.hold_cnt", 64'(hc2), 64'(m2.hc));
    chk("m2.bubble_cnt", 64'(bc2), 64'(m2.bc));
  endtask

  task automatic step(input logic r, st, bu, bs, fl, va,
                      input logic [31:0] d, p, input logic [4:0] e);
    reset = r; stall = st; busy = bu; bsens = bs; flush = fl; valid = va;
    data = d; pc = p; ex = e;
    #3;
    chk("hold_o", 64'(hold1), 64'(st | (bu & bs)));
    chk("hold_o.cnt2", 64'(hold2), 64'(st | (bu & bs)));
    @(posedge clk);
    m1 = mstep(m1, 32'h0, 32'h0, 65535);
    m2 = mstep(m2, NOP2, RPC2, 3);
    #1;
    cmp_models();
  endtask

  typedef struct {
    logic        r, st, bu, bs, fl, va;
    logic [31:0] d, p;
    logic [4:0]  e;
    logic        xv;
    logic [31:0] xd, xp;
    logic [4:0]  xe;
    logic        xpend;
    int unsigned xhc, xbc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(logic r, st, bu, bs, fl, va, logic [31:0] d, p, logic [4:0] e,
                               logic xv, logic [31:0] xd, xp, logic [4:0] xe, logic xpend,
                               int unsigned xhc, xbc);
    vec_t t;
    t.r = r; t.st = st; t.bu = bu; t.bs = bs; t.fl = fl; t.va = va;
    t.d = d; t.p = p; t.e = e;
    t.xv = xv; t.xd = xd; t.xp = xp; t.xe = xe; t.xpend = xpend; t.xhc = xhc; t.xbc = xbc;
    return t;
  endfunction

  initial begin
    reset = 1'b1; stall = 0; busy = 0; bsens = 0; flush = 0; valid = 0;
    data = '0; pc = '0; ex = '0;
    m1 = reset_state(32'h0, 32'h0);
    m2 = reset_state(NOP2, RPC2);
    @(posedge clk); #1;

    //                 r st bu bs fl va data           pc         ex  | v data          pc         ex pend hc bc
    vecs.push_back(mkv(1, 0, 0, 0, 0, 1, 32'h1111_1111, 32'h0040, 3, 0, 32'h0,         32'h0,     0, 0, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 1, 32'h2402_000A, 32'h3000, 0, 1, 32'h2402_000A, 32'h3000,  0, 0, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 0, 1, 32'h0000_0011, 32'h3100, 1, 1, 32'h2402_000A, 32'h3000,  0, 0, 1, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 0, 0, 32'h0000_0022, 32'h3200, 2, 1, 32'h2402_000A, 32'h3000,  0, 0, 2, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 0, 1, 32'h0000_0033, 32'h3300, 3, 1, 32'h2402_000A, 32'h3000,  0, 0, 3, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 1, 32'h2403_0001, 32'h3004, 0, 1, 32'h2403_0001, 32'h3004,  0, 0, 3, 0));
    vecs.push_back(mkv(0, 0, 1, 1, 0, 1, 32'h0000_0044, 32'h3400, 0, 1, 32'h2403_0001, 32'h3004,  0, 0, 4, 0));
    vecs.push_back(mkv(0, 0, 1, 1, 0, 1, 32'h0000_0055, 32'h3500, 0, 1, 32'h2403_0001, 32'h3004,  0, 0, 5, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 0, 1, 32'h2404_0002, 32'h3008, 0, 1, 32'h2404_0002, 32'h3008,  0, 0, 5, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 1, 1, 32'h0000_0066, 32'h3600, 0, 1, 32'h2404_0002, 32'h3008,  0, 1, 6, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 0, 1, 32'h0000_0077, 32'h3700, 0, 1, 32'h2404_0002, 32'h3008,  0, 1, 7, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 0, 1, 32'h0000_0088, 32'h3800, 0, 1, 32'h2404_0002, 32'h3008,  0, 1, 8, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 0, 1, 32'h0000_0099, 32'h3900, 0, 1, 32'h2404_0002, 32'h3008,  0, 1, 9, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 1, 32'h0000_AAAA, 32'h300C, 7, 0, 32'h0,         32'h300C,  0, 0, 9, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 1, 32'h2405_0003, 32'h3010, 0, 1, 32'h2405_0003, 32'h3010,  0, 0, 9, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 1, 1, 32'h2406_0004, 32'h3014, 4, 0, 32'h0,         32'h3014,  0, 0, 9, 2));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 1, 32'h0000_1234, 32'h3018, 4, 1, 32'h0000_1234, 32'h3018,  4, 0, 9, 2));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 32'h0000_5555, 32'h301C, 0, 0, 32'h0000_5555, 32'h301C,  0, 0, 9, 2));

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].st, vecs[i].bu, vecs[i].bs, vecs[i].fl, vecs[i].va,
           vecs[i].d, vecs[i].p, vecs[i].e);
      chk($sformatf("vec%0d.valid", i), 64'(v1), 64'(vecs[i].xv));
      chk($sformatf("vec%0d.data", i), 64'(d1), 64'(vecs[i].xd));
      chk($sformatf("vec%0d.pc", i), 64'(p1), 64'(vecs[i].xp));
      chk($sformatf("vec%0d.excode", i), 64'(e1), 64'(vecs[i].xe));
      chk($sformatf("vec%0d.pend", i), 64'(pend1), 64'(vecs[i].xpend));
      chk($sformatf("vec%0d.hold_cnt", i), 64'(hc1), 64'(vecs[i].xhc));
      chk($sformatf("vec%0d.bubble_cnt", i), 64'(bc1), 64'(vecs[i].xbc));
    end

    // Pending flush released together with a fresh flush_i: one bubble only.
    step(0, 1, 0, 0, 1, 1, 32'h0000_0F0F, 32'h3F00, 0);
    chk("dbl.pend_set", 64'(pend1), 64'd1);
    step(0, 0, 0, 0, 1, 1, 32'h0000_0E0E, 32'h4000, 2);
    chk("dbl.bubble_valid", 64'(v1), 64'd0);
    chk("dbl.bubble_pc", 64'(p1), 64'h4000);
    chk("dbl.bubble_cnt", 64'(bc1), 64'd3);
    chk("dbl.pend_clear", 64'(pend1), 64'd0);
    step(0, 0, 0, 0, 0, 1, 32'h0000_0077, 32'h4004, 0);
    chk("dbl.load_valid", 64'(v1), 64'd1);
    chk("dbl.load_data", 64'(d1), 64'h77);
    chk("dbl.bubble_cnt_after", 64'(bc1), 64'd3);

    // Narrow counter saturation, then reset while holding with a flush pending.
    step(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
    chk("rst.cnt2_data", 64'(d2), 64'(NOP2));
    chk("rst.cnt2_pc", 64'(p2), 64'(RPC2));
    for (int i = 0; i < 6; i++)
      step(0, 1, 0, 0, (i == 1), 1, 32'h100 + 32'(i), 32'h5000 + 32'(i), 1);
    chk("sat.hold_cnt2", 64'(hc2), 64'd3);
    chk("sat.hold_cnt16", 64'(hc1), 64'd6);
    chk("sat.pend2", 64'(pend2), 64'd1);
    step(1, 1, 0, 0, 1, 1, 32'h9999, 32'h9999, 9);
    chk("rstmid.valid", 64'(v2), 64'd0);
    chk("rstmid.data", 64'(d2), 64'(NOP2));
    chk("rstmid.pc", 64'(p2), 64'(RPC2));
    chk("rstmid.excode", 64'(e2), 64'd0);
    chk("rstmid.pend", 64'(pend2), 64'd0);
    chk("rstmid.hold_cnt", 64'(hc2), 64'd0);
    chk("rstmid.bubble_cnt", 64'(bc2), 64'd0);
    chk("rstmid.hold_cnt16", 64'(hc1), 64'd0);
    chk("rstmid.pend16", 64'(pend1), 64'd0);

    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
           $urandom, $urandom, 5'($urandom_range(0, 31)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the five-stage MIPS core. It generalises the fixed IF/ID latch to any payload width.
- Adds a valid bit, exception-code carry, and deferred flush: a flush that arrives during a hold is remembered, not dropped.
- Adds saturating hold and bubble performance counters.
- One instance per stage boundary (F/D, D/E, E/M, M/W); hazard unit drives stall/flush.

Parameters:
- DATA_W, 32, width of instruction/payload field
- PC_W, 32, width of PC field
- NOP_DATA, 0, payload value loaded on reset and on flush bubble
- RESET_PC, 0, pc_o value after reset
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- stall_i  in  1  hazard-unit stall for this stage
- busy_i  in  1  multi-cycle unit (mult/div) busy
- busy_sens_i  in  1  incoming instruction needs the multi-cycle unit (HI/LO class)
- flush_i  in  1  kill request for this stage (branch/exception)
- valid_i  in  1  incoming slot holds a real instruction
- data_i  in  DATA_W  incoming payload
- pc_i  in  PC_W  incoming PC
- excode_i  in  5  incoming exception code (0 = none)
- valid_o  out  1  registered valid
- data_o  out  DATA_W  registered payload
- pc_o  out  PC_W  registered PC
- excode_o  out  5  registered exception code
- hold_o  out  1  combinational: stage is holding this cycle
- flush_pend_o  out  1  registered: deferred flush outstanding
- hold_cnt_o  out  CNT_W  cycles spent holding
- bubble_cnt_o  out  CNT_W  flush bubbles inserted

Behaviour:
- hold = stall_i | (busy_i & busy_sens_i); hold_o = hold (combinational).
- Reset (clk edge with reset=1):
  - valid_o=0, data_o=NOP_DATA, pc_o=RESET_PC, excode_o=0
  - flush_pend_o=0, both counters 0, state=RUN
  - Reset overrides every other input, including mid-hold and pending flush.
- State machine: RUN, HOLD, HOLD_FP (hold with flush pending). flush_pend_o=1 exactly in HOLD_FP.
- Per-edge priority (reset=0):
  1. hold=1:
     - All data outputs keep their value.
     - hold_cnt increments.
     - Next state: HOLD_FP if flush_i=1 or current state is HOLD_FP; otherwise HOLD.
  2. hold=0 and (flush_i=1 or state=HOLD_FP):
     - Insert bubble: valid_o=0, data_o=NOP_DATA, excode_o=0.
     - pc_o=pc_i; PC is kept for EPC/delay-slot tracking.
     - bubble_cnt increments; state=RUN.
  3. hold=0 and no flush pending:
     - Load valid_i, data_i, pc_i, excode_i; state=RUN.
- A pending flush is consumed by exactly one bubble, on the first non-hold edge. A second flush_i on that same edge does not add an extra bubble.
- Counters saturate at all-ones and never wrap. The hold increment and bubble increment never occur on the same edge.
- Latency: one cycle from input to output when not holding; zero added latency for flush once the hold releases.
- valid_i=0 on a load propagates as valid_o=0 but does not count as a bubble.

Test Plan:
- Reset, then load data_i=0x2402000A, pc_i=0x3000, valid_i=1, excode_i=0. Next edge: data_o=0x2402000A, pc_o=0x3000, valid_o=1, counters 0.
- stall_i=1 for 3 cycles with changing inputs. Outputs frozen at prior values, hold_cnt_o=3, flush_pend_o=0, state returns to RUN after release.
- busy_i=1, busy_sens_i=1 for 2 cycles, then busy_sens_i=0 with busy_i still 1. Hold for 2 cycles, then load proceeds; hold_cnt_o=2.
- flush_i=1 for one cycle during a 4-cycle stall:
  - flush_pend_o=1 from the next edge until release.
  - First free edge gives valid_o=0, data_o=0, pc_o=pc_i, bubble_cnt_o=1.
  - Following edge loads normally.
- flush_i=1 with hold=0 and excode_i=4. Result: valid_o=0, excode_o=0, bubble_cnt_o increments by 1.
- CNT_W=2 with stall held 6 cycles: hold_cnt_o saturates at 3. Reset asserted mid-stall with flush pending clears every output and counter on that edge.
